// File: rtl/ttl_74592_if.sv
// Counter-side signal bundle of the ttl_74592: preload/control inputs and Q/RCO_bar outputs.
// Down exists only when TTL_74592_DOWN_COUNT_EN is defined.
interface ttl_74592_if #(
    parameter int WIDTH = 8
);
    logic             RCK_EN;
    logic [WIDTH-1:0] D;
    logic             CCLR_bar;
    logic             CLOAD_bar;
    logic             CCKEN_bar;
`ifdef TTL_74592_DOWN_COUNT_EN
    logic             Down;
`endif
    logic             RCO_bar;
    logic [WIDTH-1:0] Q;

`ifdef TTL_74592_DOWN_COUNT_EN
    modport master (output RCK_EN, D, CCLR_bar, CLOAD_bar, CCKEN_bar, Down,
                    input  RCO_bar, Q);
    modport slave  (input  RCK_EN, D, CCLR_bar, CLOAD_bar, CCKEN_bar, Down,
                    output RCO_bar, Q);
`else
    modport master (output RCK_EN, D, CCLR_bar, CLOAD_bar, CCKEN_bar,
                    input  RCO_bar, Q);
    modport slave  (input  RCK_EN, D, CCLR_bar, CLOAD_bar, CCKEN_bar,
                    output RCO_bar, Q);
`endif
endinterface

// File: rtl/ttl_74592_input_reg.sv
// Preload register R: stages the next start value while the counter runs.
module ttl_74592_input_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             RCK_EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;

    always_comb begin
        r_d = r_q;
        if (RCK_EN) r_d = D;
    end

    always_ff @(posedge Clk) begin
        if (Clear) r_q <= '0;
        else       r_q <= r_d;
    end

    assign R = r_q;
endmodule

// File: rtl/ttl_74592.sv
// 8-bit synchronous binary counter with a separate preload register and ripple-carry output.
// Optional down-count mode (Down port) when TTL_74592_DOWN_COUNT_EN is defined.
module ttl_74592 #(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic          Clk,
    input  logic          Clear,
    ttl_74592_if.slave    bus
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] c_d;
    logic             down;
    logic             terminal;

    ttl_74592_input_reg #(.WIDTH(WIDTH)) u_in_reg (
        .Clk    (Clk),
        .Clear  (Clear),
        .RCK_EN (bus.RCK_EN),
        .D      (bus.D),
        .R      (r_q)
    );

`ifdef TTL_74592_DOWN_COUNT_EN
    assign down = bus.Down;
`else
    assign down = 1'b0;
`endif

    // Counter clear beats transfer beats count; transfer takes the pre-edge R.
    always_comb begin
        c_d = c_q;
        if (!bus.CCLR_bar)       c_d = '0;
        else if (!bus.CLOAD_bar) c_d = r_q;
        else if (!bus.CCKEN_bar) c_d = down ? c_q - WIDTH'(1) : c_q + WIDTH'(1);
    end

    always_ff @(posedge Clk) begin
        if (Clear) c_q <= '0;
        else       c_q <= c_d;
    end

    // Ripple carry flags the terminal count regardless of count enable.
    assign terminal = down ? (c_q == '0) : (c_q == {WIDTH{1'b1}});

    assign #(DELAY_RISE, DELAY_FALL) bus.Q       = c_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.RCO_bar = ~terminal;
endmodule

// File: tb/tb_ttl_74592.sv
// Directed self-checking bench for ttl_74592; Down-mode vectors run when TTL_74592_DOWN_COUNT_EN is defined.
module tb_ttl_74592;
    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic Clk;
    logic Clear;
    int   total;
    int   bad;

    ttl_74592_if #(.WIDTH(WIDTH)) bus ();

    ttl_74592 #(.WIDTH(WIDTH), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk   (Clk),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Clear         = 1'b0;
        bus.RCK_EN    = 1'b0;
        bus.D         = '0;
        bus.CCLR_bar  = 1'b1;
        bus.CLOAD_bar = 1'b1;
        bus.CCKEN_bar = 1'b1;
`ifdef TTL_74592_DOWN_COUNT_EN
        bus.Down      = 1'b0;
`endif
    endtask

    // Apply the current inputs across one rising edge, sample 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        @(negedge Clk);
        idle();

        // Clear with hostile inputs overrides everything
        Clear = 1'b1; bus.RCK_EN = 1'b1; bus.D = 8'hFF;
        bus.CLOAD_bar = 1'b0; bus.CCKEN_bar = 1'b0;
        step();
        chk("rst_q", bus.Q, 8'h00);
        chk("rst_rco", {7'd0, bus.RCO_bar}, 8'h01);
        chk("rst_r", dut.r_q, 8'h00);
        @(negedge Clk); idle(); bus.CLOAD_bar = 1'b0;
        step();
        chk("rst_load", bus.Q, 8'h00);

        // Capture then transfer
        @(negedge Clk); idle(); bus.RCK_EN = 1'b1; bus.D = 8'hA5;
        step();
        chk("cap_q", bus.Q, 8'h00);
        @(negedge Clk); idle(); bus.CLOAD_bar = 1'b0;
        step();
        chk("xfer_q", bus.Q, 8'hA5);

        // Simultaneous capture and transfer uses the old R
        @(negedge Clk); idle(); bus.RCK_EN = 1'b1; bus.D = 8'h10;
        step();
        @(negedge Clk); idle(); bus.RCK_EN = 1'b1; bus.D = 8'h55; bus.CLOAD_bar = 1'b0;
        step();
        chk("sim_old", bus.Q, 8'h10);
        @(negedge Clk); idle(); bus.CLOAD_bar = 1'b0;
        step();
        chk("sim_new", bus.Q, 8'h55);

        // Count through wrap, RCO_bar low only at all-ones
        @(negedge Clk); idle(); bus.RCK_EN = 1'b1; bus.D = 8'hFD;
        step();
        @(negedge Clk); idle(); bus.CLOAD_bar = 1'b0;
        step();
        chk("ld_fd", bus.Q, 8'hFD);
        chk("rco_fd", {7'd0, bus.RCO_bar}, 8'h01);
        @(negedge Clk); idle(); bus.CCKEN_bar = 1'b0;
        step();
        chk("cnt_fe", bus.Q, 8'hFE);
        chk("rco_fe", {7'd0, bus.RCO_bar}, 8'h01);
        step();
        chk("cnt_ff", bus.Q, ALL_ONES);
        chk("rco_ff", {7'd0, bus.RCO_bar}, 8'h00);
        @(negedge Clk); idle();
        step();
        chk("hold_ff", bus.Q, ALL_ONES);
        chk("rco_hold", {7'd0, bus.RCO_bar}, 8'h00);
        @(negedge Clk); bus.CCKEN_bar = 1'b0;
        step();
        chk("wrap_00", bus.Q, 8'h00);
        chk("rco_00", {7'd0, bus.RCO_bar}, 8'h01);

        // Counter clear wins over load/count while R still captures
        @(negedge Clk); idle(); bus.RCK_EN = 1'b1; bus.D = 8'h40;
        step();
        @(negedge Clk); idle(); bus.CLOAD_bar = 1'b0;
        step();
        chk("ld_40", bus.Q, 8'h40);
        @(negedge Clk); idle();
        bus.CCLR_bar = 1'b0; bus.CLOAD_bar = 1'b0; bus.CCKEN_bar = 1'b0;
        bus.RCK_EN = 1'b1; bus.D = 8'h77;
        step();
        chk("cclr_q", bus.Q, 8'h00);
        chk("cclr_r", dut.r_q, 8'h77);

        // Load has priority over count
        @(negedge Clk); idle(); bus.CLOAD_bar = 1'b0; bus.CCKEN_bar = 1'b0;
        step();
        chk("ld_pri", bus.Q, 8'h77);
        @(negedge Clk); idle(); bus.CCKEN_bar = 1'b0;
        step();
        chk("cnt_78", bus.Q, 8'h78);

        // Clear mid-count discards the pending transfer
        @(negedge Clk); Clear = 1'b1; bus.CLOAD_bar = 1'b0;
        step();
        chk("clr_q", bus.Q, 8'h00);
        chk("clr_r", dut.r_q, 8'h00);
        @(negedge Clk); idle(); bus.CCKEN_bar = 1'b0;
        step();
        chk("resume", bus.Q, 8'h01);

`ifdef TTL_74592_DOWN_COUNT_EN
        @(negedge Clk); idle(); bus.RCK_EN = 1'b1; bus.D = 8'h01;
        step();
        @(negedge Clk); idle(); bus.CLOAD_bar = 1'b0; bus.Down = 1'b1;
        step();
        chk("dn_ld", bus.Q, 8'h01);
        chk("dn_rco1", {7'd0, bus.RCO_bar}, 8'h01);
        @(negedge Clk); idle(); bus.Down = 1'b1; bus.CCKEN_bar = 1'b0;
        step();
        chk("dn_00", bus.Q, 8'h00);
        chk("dn_rco0", {7'd0, bus.RCO_bar}, 8'h00);
        step();
        chk("dn_ff", bus.Q, ALL_ONES);
        chk("dn_rcoff", {7'd0, bus.RCO_bar}, 8'h01);
        @(negedge Clk); bus.Down = 1'b0; bus.CCKEN_bar = 1'b1;
        #1;
        chk("up_rcoff", {7'd0, bus.RCO_bar}, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
